// File: rtl/wshb_slv_mem.sv
// wshb_slv_mem: Wishbone classic slave responder backed by a word-addressed RAM.
//
// A request seen in IDLE (cyc & stb) is captured and classified. After
// WAIT_STATES idle cycles it is terminated by a single-cycle ack, err or rty.
// The RAM is split into one byte-wide lane per byte enable, so masked writes
// only touch the selected lanes.
//
// Optional feature: define WSHB_SLV_RTY_EN to make every RTY_PERIOD-th
// in-range request terminate with rty instead of ack.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   wb_adr_i        byte address; low log2(DWIDTH/8) bits are ignored
//   wb_dat_i        write data
//   wb_sel_i        byte enables
//   wb_cyc_i        bus cycle valid
//   wb_stb_i        strobe
//   wb_we_i         1 = write, 0 = read
//   wb_dat_o        read data; 0 unless a read is being acked
//   wb_ack_o        normal termination
//   wb_err_o        error termination (address out of range)
//   wb_rty_o        retry termination
//   txn_cnt         number of terminated transactions, wraps

// One byte lane of the RAM. Writes are synchronous; reads are asynchronous.
// The top level registers the read data.
module wshb_slv_mem_lane #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] idx,
  input  logic [7:0]        wdat,
  output logic [7:0]        rdat
);
  logic [7:0] mem [2**MEM_AW];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdat;

  assign rdat = mem[idx];
endmodule

module wshb_slv_mem #(
  parameter int DWIDTH      = 64,
  parameter int AWIDTH      = 32,
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 0,
  parameter int RTY_PERIOD  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AWIDTH-1:0]   wb_adr_i,
  input  logic [DWIDTH-1:0]   wb_dat_i,
  input  logic [DWIDTH/8-1:0] wb_sel_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  output logic [DWIDTH-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [31:0]         txn_cnt
);
  localparam int NUM_LANES = DWIDTH / 8;
  localparam int BO        = $clog2(NUM_LANES);
  localparam int HI        = MEM_AW + BO;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {RSP_ACK, RSP_ERR, RSP_RTY} rsp_t;

  typedef struct packed {
    logic [MEM_AW-1:0]         idx;
    logic [NUM_LANES-1:0][7:0] dat;
    logic [NUM_LANES-1:0]      sel;
    logic                      we;
    rsp_t                      rsp;
  } req_t;

  state_t                    state;
  req_t                      req;
  logic [3:0]                wcnt;
  logic                      req_hit;
  logic                      oor;
  logic                      rty_hit;
  rsp_t                      rsp_new;
  logic [NUM_LANES-1:0]      we_lane;
  logic [NUM_LANES-1:0][7:0] rd_word;

  assign req_hit = wb_cyc_i & wb_stb_i;
  // Any address bit above the RAM window makes the access out of range.
  assign oor     = |(wb_adr_i >> HI);

  generate
    if (BO > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^wb_adr_i[BO-1:0];
    end
  endgenerate

`ifdef WSHB_SLV_RTY_EN
  localparam int             RCW      = (RTY_PERIOD > 1) ? $clog2(RTY_PERIOD) : 1;
  localparam logic [RCW-1:0] RTY_LAST = RCW'(RTY_PERIOD - 1);

  logic [RCW-1:0] rty_cnt;
  logic           rty_q;

  // rty_hit: this accepted request makes the counter wrap to 0.
  assign rty_hit  = (rty_cnt == RTY_LAST);
  assign wb_rty_o = rty_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rty_cnt <= '0;
      rty_q   <= 1'b0;
    end else begin
      rty_q <= (state == S_RESP) && (req.rsp == RSP_RTY);
      if (state == S_IDLE && req_hit && !oor)
        rty_cnt <= rty_hit ? '0 : rty_cnt + 1'b1;
    end
`else
  assign rty_hit  = 1'b0;
  assign wb_rty_o = 1'b0;
`endif

  // Error beats retry. An out-of-range request never advances the retry counter.
  assign rsp_new = oor ? RSP_ERR : (rty_hit ? RSP_RTY : RSP_ACK);

  // RAM writes happen only in the response cycle of an acked write.
  // A transaction that is aborted or cut off by reset never gets there.
  assign we_lane = (state == S_RESP && req.rsp == RSP_ACK && req.we) ? req.sel : '0;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      wshb_slv_mem_lane #(.MEM_AW(MEM_AW)) u_lane (
        .clk  (clk),
        .we   (we_lane[i]),
        .idx  (req.idx),
        .wdat (req.dat[i]),
        .rdat (rd_word[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_IDLE;
      req      <= '0;
      wcnt     <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      txn_cnt  <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      case (state)
        S_IDLE:
          if (req_hit) begin
            req.idx <= wb_adr_i[HI-1:BO];
            req.dat <= wb_dat_i;
            req.sel <= wb_sel_i;
            req.we  <= wb_we_i;
            req.rsp <= rsp_new;
            wcnt    <= 4'(WAIT_STATES);
            state   <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        S_WAIT:
          // The master dropping cyc abandons the request silently.
          if (!wb_cyc_i) state <= S_IDLE;
          else begin
            wcnt <= wcnt - 4'd1;
            if (wcnt == 4'd1) state <= S_RESP;
          end
        S_RESP: begin
          txn_cnt <= txn_cnt + 32'd1;
          case (req.rsp)
            RSP_ACK: begin
              wb_ack_o <= 1'b1;
              if (!req.we) wb_dat_o <= rd_word;
            end
            RSP_ERR: wb_err_o <= 1'b1;
            default: ;
          endcase
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_wshb_slv_mem.sv
// Bench for wshb_slv_mem. Two instances share the clock and reset: dut 0 has
// no wait states and dut 1 has three. A byte-level reference memory, a
// transaction count and an in-range acceptance count give the expected values.
module tb_wshb_slv_mem;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int MAW = 10;
  localparam int RP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] adr   [2];
  logic [DW-1:0] dat_w [2];
  logic [7:0]    sel   [2];
  logic          cyc   [2];
  logic          stb   [2];
  logic          we    [2];
  logic [DW-1:0] dat_r [2];
  logic          ack   [2];
  logic          err   [2];
  logic          rty   [2];
  logic [31:0]   txn   [2];

  wshb_slv_mem #(.DWIDTH(DW), .AWIDTH(AW), .MEM_AW(MAW), .WAIT_STATES(0), .RTY_PERIOD(RP)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]), .wb_sel_i(sel[0]),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_dat_o(dat_r[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]), .txn_cnt(txn[0]));

  wshb_slv_mem #(.DWIDTH(DW), .AWIDTH(AW), .MEM_AW(MAW), .WAIT_STATES(3), .RTY_PERIOD(RP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]), .wb_sel_i(sel[1]),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_dat_o(dat_r[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]), .txn_cnt(txn[1]));

  int n_cmp = 0;
  int n_err = 0;
  int ws_of [2] = '{0, 3};

  logic [63:0] mref  [2][1024];
  bit          known [2][1024];
  logic [31:0] txn_m [2];
  int          inr_m [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 = ack, 1 = err, 2 = rty for a request accepted now on bus d.
  function automatic int classify(input int d, input logic [31:0] a);
    if ((a >> 13) != 0) return 1;
    inr_m[d]++;
`ifdef WSHB_SLV_RTY_EN
    if (inr_m[d] % RP == 0) return 2;
`endif
    return 0;
  endfunction

  // Called at a negedge. Drives one request, checks its termination and
  // returns at the negedge where the termination was seen. With keep=1 the
  // strobe stays high so the next call is a back-to-back request.
  task automatic xfer(input int d, input logic [31:0] a, input logic [63:0] wd,
                      input logic [7:0] s, input logic w, input bit keep);
    int          rsp;
    int          idx;
    int          lat;
    bit          got;
    logic [63:0] exp_rd;
    cyc[d] = 1'b1; stb[d] = 1'b1; adr[d] = a; dat_w[d] = wd; sel[d] = s; we[d] = w;
    idx    = int'((a >> 3) & 32'h3FF);
    rsp    = classify(d, a);
    exp_rd = mref[d][idx];
    @(posedge clk);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 24 && !got; k++) begin
      @(negedge clk);
      if (ack[d] | err[d] | rty[d]) begin
        got = 1'b1;
        lat = k - 1;
      end
    end
    chk("term_seen", 64'(got), 64'd1);
    if (got) begin
      txn_m[d]++;
      chk("latency", 64'(lat), 64'(ws_of[d] + 1));
      chk("ack", 64'(ack[d]), 64'(rsp == 0));
      chk("err", 64'(err[d]), 64'(rsp == 1));
      chk("rty", 64'(rty[d]), 64'(rsp == 2));
      if (rsp == 0 && !w && known[d][idx]) chk("rdata", dat_r[d], exp_rd);
      if (rsp != 0) chk("dat_zero", dat_r[d], 64'd0);
      chk("txn", 64'(txn[d]), 64'(txn_m[d]));
      if (rsp == 0 && w) begin
        for (int b = 0; b < 8; b++)
          if (s[b]) mref[d][idx][b*8 +: 8] = wd[b*8 +: 8];
        if (s == 8'hFF) known[d][idx] = 1'b1;
      end
    end
    if (!keep || !got) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      @(negedge clk);
      chk("one_cycle", 64'({ack[d], err[d], rty[d]}), 64'd0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ack"}, 64'(ack[d]), 64'd0);
      chk({tag, "_err"}, 64'(err[d]), 64'd0);
      chk({tag, "_rty"}, 64'(rty[d]), 64'd0);
      chk({tag, "_dat"}, dat_r[d], 64'd0);
      chk({tag, "_txn"}, 64'(txn[d]), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit          pk;
    int          d;
    logic [31:0] a;
    logic [63:0] wd;
    logic [7:0]  s;
    logic        w;
    bit          kp;
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; dat_w[i] = '0; sel[i] = '0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      txn_m[i] = '0; inr_m[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Write, read, byte-masked write, read back on the zero-wait instance.
    xfer(0, 32'h10, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b0);
    xfer(0, 32'h10, 64'h0, 8'hFF, 1'b0, 1'b0);
    chk("txn_two", 64'(txn[0]), 64'd2);
    xfer(0, 32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b1, 1'b0);
    xfer(0, 32'h10, 64'h0, 8'h00, 1'b0, 1'b0);

    // An out-of-range write returns err and leaves word 0 alone.
    xfer(0, 32'h0, 64'hA5A5_5A5A_1234_5678, 8'hFF, 1'b1, 1'b0);
    xfer(0, 32'h2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1, 1'b0);
    xfer(0, 32'h0, 64'h0, 8'hFF, 1'b0, 1'b0);

    // A strobe without cyc is ignored.
    stb[0] = 1'b1; adr[0] = 32'h8; we[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_cyc_term", 64'({ack[0], err[0], rty[0]}), 64'd0);
    end
    stb[0] = 1'b0; we[0] = 1'b0;
    chk("no_cyc_txn", 64'(txn[0]), 64'(txn_m[0]));

    // Back-to-back requests with the strobe held high.
    xfer(0, 32'h18, 64'h1111_2222_3333_4444, 8'hFF, 1'b1, 1'b1);
    xfer(0, 32'h18, 64'h0, 8'hFF, 1'b0, 1'b1);
    xfer(0, 32'h20, 64'h5555_6666_7777_8888, 8'hFF, 1'b1, 1'b0);

    // Three wait states on dut 1.
    xfer(1, 32'h40, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 1'b1, 1'b0);
    xfer(1, 32'h40, 64'h0, 8'hFF, 1'b0, 1'b0);

    // Abort: cyc drops one cycle after the capture.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40;
    dat_w[1] = 64'h0; sel[1] = 8'hFF;
    void'(classify(1, 32'h40));
    @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_term", 64'({ack[1], err[1], rty[1]}), 64'd0);
    end
    chk("abort_txn", 64'(txn[1]), 64'(txn_m[1]));
    xfer(1, 32'h40, 64'h0, 8'hFF, 1'b0, 1'b0);

    // Prefill a small window, then random traffic.
    for (int i = 0; i < 16; i++) begin
      xfer(0, 32'(i * 8), {$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
      xfer(1, 32'(i * 8), {$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
    end
    pk = 1'b0;
    d  = 0;
    for (int i = 0; i < 300; i++) begin
      if (!pk) d = int'($urandom_range(0, 1));
      a = (32'($urandom_range(0, 15)) << 3) | 32'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(13, 31));
      wd = {$urandom, $urandom};
      s  = 8'($urandom);
      w  = 1'($urandom);
      kp = (i != 299) && ($urandom_range(0, 3) == 0);
      xfer(d, a, wd, s, w, kp);
      pk = kp;
    end

    // Reset during the wait phase: outputs clear at once and the write is lost.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h48;
    dat_w[1] = 64'h0F0F_0F0F_F0F0_F0F0; sel[1] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      txn_m[i] = '0;
      inr_m[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1, 32'h48, 64'h0, 8'hFF, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wshb_slv_mem.md
Name: wshb_slv_mem

Overview:
- Wishbone classic slave responder with an internal word-addressed RAM.
- Sits directly downstream of the Wishbone master bus-functional model in the wishbone_bfm bench and consumes its cycles.
- Returns ack, err or rty with programmable wait states so master timing paths get exercised.
- Exposes a transaction counter for scoreboarding.

Parameters:
- DWIDTH, 64, data width in bits; multiple of 8.
- AWIDTH, 32, byte address width.
- MEM_AW, 10, log2 of RAM depth in words.
- WAIT_STATES, 0, idle cycles inserted between request capture and response (0..15).
- RTY_PERIOD, 4, with retry feature: every RTY_PERIOD-th accepted transaction answers rty (≥2).

Ports:
- clk  in  1  bench clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_adr_i  in  AWIDTH  byte address from master.
- wb_dat_i  in  DWIDTH  write data from master.
- wb_sel_i  in  DWIDTH/8  byte enables.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_dat_o  out  DWIDTH  read data; valid only while wb_ack_o = 1, else 0.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry termination.
- txn_cnt  out  32  count of terminated transactions (ack + err + rty), wraps at 2^32.

Behaviour:
- Reset, asynchronous on rst_n low:
  - wb_ack_o, wb_err_o, wb_rty_o and wb_dat_o go to 0.
  - txn_cnt goes to 0 and the FSM goes to IDLE.
  - RAM contents are not cleared.
- Word index = wb_adr_i[MEM_AW+BO-1:BO], where BO = log2(DWIDTH/8). Low BO address bits are ignored.
- Out of range: any wb_adr_i bit at or above MEM_AW+BO set.
- FSM states IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - When wb_cyc_i & wb_stb_i: capture adr/dat/sel/we, classify the response, load the wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else go to RESP.
- WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 0.
  - If wb_cyc_i drops, abort: go to IDLE with no response, no RAM write and no txn_cnt change.
- RESP:
  - Drive exactly one termination signal high for exactly one cycle.
  - Increment txn_cnt.
  - Return to IDLE unconditionally.
  - Ack, write: RAM bytes with wb_sel_i[k] = 1 are updated from the captured data; bytes with sel = 0 are preserved.
  - Ack, read: wb_dat_o = RAM word (all bytes, sel ignored).
  - Err: RAM untouched, wb_dat_o = 0.
- Latency from request capture edge to termination: WAIT_STATES + 1 cycles.
- Back-to-back: if stb is still high in the cycle after termination, IDLE treats it as a new request. Minimum spacing is 2 cycles per transaction at WAIT_STATES = 0.
- Mutual exclusion: at most one of ack/err/rty is high in any cycle. Error takes priority over retry.
- wb_cyc_i low with wb_stb_i high is ignored.
- Reset asserted mid-transaction: the pending write is not committed and no termination is issued.

Optional Feature:
- Macro WSHB_SLV_RTY_EN.
- Defined:
  - A modulo-RTY_PERIOD counter advances on each in-range transaction accepted in IDLE.
  - When it wraps to 0, that transaction terminates with wb_rty_o instead of ack.
  - Retried accesses do not touch RAM; they do increment txn_cnt.
  - Reset clears the counter.
- Undefined: wb_rty_o is tied to 0 and the counter logic is absent.

Test Plan:
- Write then read, WAIT_STATES=0: write 0x0123456789ABCDEF to adr 0x10, sel=0xFF → ack 1 cycle after capture; read adr 0x10 → wb_dat_o=0x0123456789ABCDEF with ack; txn_cnt=2.
- Byte enables: over 0x0123456789ABCDEF, write 0xFFFFFFFFFFFFFFFF with sel=0x0F to adr 0x10 → read returns 0x01234567FFFFFFFF.
- Wait states, WAIT_STATES=3: read request captured at edge N → wb_ack_o high only at edge N+4, low at N+5.
- Out of range: MEM_AW=10, access adr 0x2000 → wb_err_o for 1 cycle, wb_ack_o=0; a subsequent read of adr 0x0 shows its prior data unchanged.
- Abort, WAIT_STATES=3: drop wb_cyc_i 1 cycle after a write capture → no termination; read back old data; txn_cnt not incremented.
- Retry, with WSHB_SLV_RTY_EN and RTY_PERIOD=4: 8 in-range writes → transactions 4 and 8 get wb_rty_o and their RAM words are unchanged; txn_cnt=8. Pulling rst_n low mid-WAIT → all outputs 0 immediately.
